// File: rtl/mux_arb_n_if.sv
`default_nettype none
// ============================================================================
// mux_arb_n_if : handshake bundle for the N-channel registered selector
// Rev 1.0
// ============================================================================
interface mux_arb_n_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4
);
  localparam int SELW = (N > 1) ? $clog2(N) : 1;

  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [N*WIDTH-1:0]   in_data;
  logic [N-1:0]         in_valid;
  logic [N-1:0]         in_ready;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [SELW-1:0]      out_chan;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_chan
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_chan
  );
endinterface
`default_nettype wire

// File: rtl/mux_arb_n.sv
`default_nettype none
// ============================================================================
// mux_arb_n : N-channel registered selector, explicit-select or round-robin
// Rev 1.0
// ============================================================================
module mux_arb_n #(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  mux_arb_n_if.slave    bus
);
  localparam int SELW = (N > 1) ? $clog2(N) : 1;

  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  out_chan_q,  out_chan_d;
  logic [SELW-1:0]  ptr_q,       ptr_d;

  logic             w_free;
  logic             w_rr_lo_ok, w_rr_hi_ok;
  logic [SELW-1:0]  w_rr_lo,    w_rr_hi;
  logic [SELW-1:0]  w_cand;
  logic             w_cand_ok;
  logic             w_cand_valid;
  logic [WIDTH-1:0] w_cand_data;
  logic [N-1:0]     w_ready;
  logic             w_xfer;

  assign w_free = !out_valid_q || bus.out_ready;

  // Round-robin: lowest valid channel above ptr wins, else lowest at/below ptr.
  always_comb begin
    w_rr_lo_ok = 1'b0;
    w_rr_hi_ok = 1'b0;
    w_rr_lo    = '0;
    w_rr_hi    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.in_valid[i]) begin
        if (i > int'(ptr_q)) begin
          w_rr_hi_ok = 1'b1;
          w_rr_hi    = SELW'(i);
        end else begin
          w_rr_lo_ok = 1'b1;
          w_rr_lo    = SELW'(i);
        end
      end
    end
  end

  always_comb begin
    if (bus.mode) begin
      w_cand    = w_rr_hi_ok ? w_rr_hi : w_rr_lo;
      w_cand_ok = w_rr_hi_ok || w_rr_lo_ok;
    end else begin
      w_cand    = bus.sel;
      w_cand_ok = (int'(bus.sel) < N);
    end
  end

  always_comb begin
    w_cand_data  = '0;
    w_cand_valid = 1'b0;
    w_ready      = '0;
    for (int i = 0; i < N; i++) begin
      if (w_cand == SELW'(i)) begin
        w_cand_data  = bus.in_data[i*WIDTH +: WIDTH];
        w_cand_valid = bus.in_valid[i];
        // Ready is held low while reset is asserted.
        w_ready[i]   = rst_n && w_free && w_cand_ok;
      end
    end
  end

  assign w_xfer = w_free && w_cand_ok && w_cand_valid;

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (w_xfer) begin
      out_data_d  = w_cand_data;
      out_valid_d = 1'b1;
      out_chan_d  = w_cand;
      if (bus.mode) begin
        ptr_d = w_cand;
      end
    end else if (w_free) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      ptr_q       <= SELW'(N - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_chan  = out_chan_q;
endmodule
`default_nettype wire

// File: tb/tb_mux_arb_n.sv
`default_nettype none
// ============================================================================
// tb_mux_arb_n : directed self-checking bench, N=4/WIDTH=32 and N=3/WIDTH=8
// Rev 1.0
// ============================================================================
module tb_mux_arb_n;
  logic clk;
  logic rst_n;
  int   n_run;
  int   n_fail;

  mux_arb_n_if #(.WIDTH(32), .N(4)) bus4 ();
  mux_arb_n_if #(.WIDTH(8),  .N(3)) bus3 ();

  mux_arb_n #(.WIDTH(32), .N(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  mux_arb_n #(.WIDTH(8),  .N(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus4.mode = 1'b0; bus4.sel = '0; bus4.in_data = '0; bus4.in_valid = '0; bus4.out_ready = 1'b0;
    bus3.mode = 1'b0; bus3.sel = '0; bus3.in_data = '0; bus3.in_valid = '0; bus3.out_ready = 1'b0;

    #2;
    chk("rst_in_ready4", bus4.in_ready, 4'b0000);
    chk("rst_out_valid4", bus4.out_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready4", bus4.in_ready, 4'b0001);
    chk("rel_in_ready3", bus3.in_ready, 3'b001);
    chk("rel_out_data4", bus4.out_data, 32'h0);
    chk("rel_out_chan4", bus4.out_chan, 2'd0);

    // explicit select on dut4, out-of-range select on dut3
    bus4.sel      = 2'd2;
    bus4.in_data  = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0000_0000};
    bus4.in_valid = 4'b1111;
    bus4.out_ready = 1'b1;
    bus3.sel      = 2'd3;
    bus3.in_data  = {8'h33, 8'h22, 8'h11};
    bus3.in_valid = 3'b111;
    bus3.out_ready = 1'b1;
    #1;
    chk("m0_in_ready_pre", bus4.in_ready, 4'b0100);
    chk("oor_in_ready3", bus3.in_ready, 3'b000);
    tick();
    chk("m0_out_data", bus4.out_data, 32'hDEAD_BEEF);
    chk("m0_out_chan", bus4.out_chan, 2'd2);
    chk("m0_out_valid", bus4.out_valid, 1'b1);
    chk("m0_in_ready", bus4.in_ready, 4'b0100);
    chk("oor_out_valid3_a", bus3.out_valid, 1'b0);
    tick();
    chk("oor_out_valid3_b", bus3.out_valid, 1'b0);

    // backpressure
    bus4.sel     = 2'd1;
    bus4.in_data = {32'h3333_3333, 32'hDEAD_BEEF, 32'h0000_0011, 32'h0000_0000};
    tick();
    chk("bp_first_data", bus4.out_data, 32'h11);
    chk("bp_first_chan", bus4.out_chan, 2'd1);
    bus4.in_data[63:32] = 32'h0000_0022;
    bus4.out_ready      = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_hold_ready", bus4.in_ready, 4'b0000);
      chk("bp_hold_data", bus4.out_data, 32'h11);
      tick();
    end
    chk("bp_hold_valid", bus4.out_valid, 1'b1);
    chk("bp_hold_data_end", bus4.out_data, 32'h11);
    bus4.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", bus4.in_ready, 4'b0010);
    tick();
    chk("bp_next_data", bus4.out_data, 32'h22);
    chk("bp_next_valid", bus4.out_valid, 1'b1);
    bus4.in_valid = 4'b0000;
    tick();
    chk("idle_valid", bus4.out_valid, 1'b0);
    chk("idle_data_hold", bus4.out_data, 32'h22);

    // round-robin on both instances
    bus4.mode     = 1'b1;
    bus4.in_valid = 4'b1111;
    bus4.in_data  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    bus3.mode     = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr4_chan", bus4.out_chan, 64'(k % 4));
      chk("rr4_data", bus4.out_data, 64'(32'hA0 + k % 4));
      if (k < 4) chk("rr3_chan", bus3.out_chan, 64'(k % 3));
    end
    bus4.in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr4_alt_chan", bus4.out_chan, (k % 2 == 0) ? 64'd1 : 64'd3);
    end

    // mode switch: ptr must survive explicit-select transfers
    bus4.in_valid = 4'b0010;
    tick();
    chk("sw_rr_chan1", bus4.out_chan, 2'd1);
    bus4.mode     = 1'b0;
    bus4.sel      = 2'd0;
    bus4.in_valid = 4'b1111;
    tick();
    chk("sw_m0_chan0", bus4.out_chan, 2'd0);
    chk("sw_m0_data", bus4.out_data, 32'hA0);
    bus4.mode = 1'b1;
    #1;
    chk("sw_rr_ready", bus4.in_ready, 4'b0100);
    tick();
    chk("sw_rr_chan2", bus4.out_chan, 2'd2);

    // asynchronous reset in the middle of a stall
    bus4.out_ready = 1'b0;
    bus4.mode      = 1'b0;
    bus4.sel       = 2'd0;
    #2;
    chk("stall_valid_pre", bus4.out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", bus4.out_valid, 1'b0);
    chk("arst_data", bus4.out_data, 32'h0);
    chk("arst_chan", bus4.out_chan, 2'd0);
    chk("arst_ready", bus4.in_ready, 4'b0000);
    tick();
    rst_n = 1'b1;
    #1;
    chk("arst_rel_ready", bus4.in_ready, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
